// File: rtl/spike_index_scheduler.sv
// Hot-vector to ascending event-index scheduler with a registered head stage.
// Optional SPIKE_SCHED_MERGE_EN: accept and OR in new vectors while draining.
module spike_index_scheduler #(
  parameter int VEC_W = 98,
  parameter int IDX_W = 7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_valid_i,
  input  logic [VEC_W-1:0] load_vec_i,
  output logic             load_ready_o,
  input  logic             abort_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  input  logic             out_ready_i,
  output logic             done_o,
  output logic [IDX_W-1:0] count_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [VEC_W-1:0] r_pend;
  logic [VEC_W-1:0] w_low;
  logic [VEC_W-1:0] w_pend_clr;
  logic [VEC_W-1:0] w_merge;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] w_sel_idx;
  logic             r_done_z;
  logic             w_hs;
  logic             w_adv;
  logic             w_take;
  logic             w_load;
  logic             w_drain;
  logic             w_quiet;
  logic             w_fin_hs;
  logic             w_fin_z;

  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(VEC_W);

  // Lowest set bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_sel_idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_low      = r_pend & (~r_pend + VEC_W'(1));
  assign w_drain    = (r_state == DRAIN);
  assign w_hs       = r_out_valid & out_ready_i;
  assign w_adv      = ~r_out_valid | out_ready_i;
  assign w_take     = w_drain & w_adv & (r_pend != '0);
  assign w_pend_clr = w_take ? (r_pend & ~w_low) : r_pend;
  assign w_load     = load_valid_i & load_ready_o & ~abort_i;

`ifdef SPIKE_SCHED_MERGE_EN
  assign w_merge = (w_load && w_drain) ? load_vec_i : '0;
`else
  assign w_merge = '0;
`endif

  assign w_quiet  = w_drain & ~abort_i & (r_pend == '0) & (w_merge == '0);
  assign w_fin_hs = w_quiet & w_hs;
  assign w_fin_z  = w_quiet & ~r_out_valid;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_load) w_next = DRAIN;
      DRAIN: if (abort_i || w_fin_hs || w_fin_z) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != IDLE);
`ifdef SPIKE_SCHED_MERGE_EN
    load_ready_o = 1'b1;
`else
    load_ready_o = (r_state == IDLE);
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_count     <= '0;
      r_done_z    <= 1'b0;
    end else begin
      r_done_z <= w_fin_z;
      if (abort_i) begin
        r_pend      <= '0;
        r_out_valid <= 1'b0;
      end else if (!w_drain) begin
        r_out_valid <= 1'b0;
        if (w_load) begin
          r_pend  <= load_vec_i;
          r_count <= '0;
        end
      end else begin
        r_pend <= w_pend_clr | w_merge;
        if (w_hs && r_count != CNT_MAX) r_count <= r_count + 1'b1;
        if (w_take) begin
          r_out_valid <= 1'b1;
          r_out_idx   <= w_sel_idx;
        end else if (w_adv) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_idx_o   = r_out_idx;
  assign count_o     = r_count;
  assign done_o      = w_fin_hs | r_done_z;

endmodule

// File: tb/tb_spike_index_scheduler.sv
// Directed bench for spike_index_scheduler.
// Define SPIKE_SCHED_MERGE_EN to also exercise merge loads.
module tb_spike_index_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        load_valid_i;
  logic [97:0] load_vec_i;
  logic        load_ready_o;
  logic        abort_i;
  logic        out_valid_o;
  logic [6:0]  out_idx_o;
  logic        out_ready_i;
  logic        done_o;
  logic [6:0]  count_o;
  logic        busy_o;

  int n_run  = 0;
  int n_fail = 0;

  spike_index_scheduler dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_valid_i (load_valid_i),
    .load_vec_i   (load_vec_i),
    .load_ready_o (load_ready_o),
    .abort_i      (abort_i),
    .out_valid_o  (out_valid_o),
    .out_idx_o    (out_idx_o),
    .out_ready_i  (out_ready_i),
    .done_o       (done_o),
    .count_o      (count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Move into the next cycle; inputs are then set and outputs checked.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i      = 1'b1;
    load_valid_i = 1'b0;
    load_vec_i   = '0;
    abort_i      = 1'b0;
    out_ready_i  = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid_o), 0);
    check("rst_idx",   32'(out_idx_o), 0);
    check("rst_done",  32'(done_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    cyc();
    cyc();
    reset_i = 1'b0;
    cyc();

    // Bits {0,2}, consumer always ready
    load_valid_i = 1'b1;
    load_vec_i   = 98'h5;
    out_ready_i  = 1'b1;
    settle();
    check("t1_ready", 32'(load_ready_o), 1);
    check("t1_idle",  32'(busy_o), 0);
    cyc();
    load_valid_i = 1'b0;
    settle();
    check("t1_busy",   32'(busy_o), 1);
    check("t1_nv1",    32'(out_valid_o), 0);
    check("t1_cnt0",   32'(count_o), 0);
`ifndef SPIKE_SCHED_MERGE_EN
    check("t1_nready", 32'(load_ready_o), 0);
`endif
    cyc();
    settle();
    check("t1_v2",   32'(out_valid_o), 1);
    check("t1_i2",   32'(out_idx_o), 0);
    check("t1_d2",   32'(done_o), 0);
    cyc();
    settle();
    check("t1_v3",   32'(out_valid_o), 1);
    check("t1_i3",   32'(out_idx_o), 2);
    check("t1_d3",   32'(done_o), 1);
    cyc();
    settle();
    check("t1_d4",   32'(done_o), 0);
    check("t1_b4",   32'(busy_o), 0);
    check("t1_cnt",  32'(count_o), 2);

    // Bits {97,8,7}, stall 3 cycles
    load_valid_i = 1'b1;
    load_vec_i   = '0;
    load_vec_i[97] = 1'b1;
    load_vec_i[8]  = 1'b1;
    load_vec_i[7]  = 1'b1;
    out_ready_i  = 1'b0;
    cyc();
    load_valid_i = 1'b0;
    settle();
    check("t2_cnt0", 32'(count_o), 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t2_stall_v", 32'(out_valid_o), 1);
      check("t2_stall_i", 32'(out_idx_o), 7);
      check("t2_stall_c", 32'(count_o), 0);
`ifndef SPIKE_SCHED_MERGE_EN
      check("t2_nready", 32'(load_ready_o), 0);
`endif
      cyc();
    end
    out_ready_i = 1'b1;
    settle();
    check("t2_i7", 32'(out_idx_o), 7);
    check("t2_d7", 32'(done_o), 0);
    cyc();
    settle();
    check("t2_i8", 32'(out_idx_o), 8);
    cyc();
    settle();
    check("t2_i97", 32'(out_idx_o), 97);
    check("t2_d97", 32'(done_o), 1);
    cyc();
    settle();
    check("t2_cnt", 32'(count_o), 3);
    check("t2_idle", 32'(busy_o), 0);

    // All-zero vector
    load_valid_i = 1'b1;
    load_vec_i   = '0;
    cyc();
    load_valid_i = 1'b0;
    settle();
    check("t3_v1", 32'(out_valid_o), 0);
    check("t3_d1", 32'(done_o), 0);
    cyc();
    settle();
    check("t3_v2", 32'(out_valid_o), 0);
    check("t3_d2", 32'(done_o), 1);
    check("t3_c2", 32'(count_o), 0);
    cyc();
    settle();
    check("t3_d3", 32'(done_o), 0);
    check("t3_b3", 32'(busy_o), 0);

    // All-ones, abort after 10 handshakes
    load_valid_i = 1'b1;
    load_vec_i   = '1;
    cyc();
    load_valid_i = 1'b0;
    cyc();
    for (int k = 0; k < 10; k++) begin
      settle();
      check("t4_idx", 32'(out_idx_o), 32'(k));
      check("t4_cnt", 32'(count_o), 32'(k));
      cyc();
    end
    abort_i = 1'b1;
    settle();
    check("t4_ab_i", 32'(out_idx_o), 10);
    check("t4_ab_d", 32'(done_o), 0);
    cyc();
    abort_i = 1'b0;
    settle();
    check("t4_busy",  32'(busy_o), 0);
    check("t4_valid", 32'(out_valid_o), 0);
    check("t4_cnt",   32'(count_o), 10);
    check("t4_ready", 32'(load_ready_o), 1);
    check("t4_done",  32'(done_o), 0);
    cyc();
    settle();
    check("t4_done2", 32'(done_o), 0);

    // Reset mid-drain of {3,50}
    load_valid_i = 1'b1;
    load_vec_i   = '0;
    load_vec_i[3]  = 1'b1;
    load_vec_i[50] = 1'b1;
    cyc();
    load_valid_i = 1'b0;
    cyc();
    settle();
    check("t5_i3", 32'(out_idx_o), 3);
    reset_i = 1'b1;
    settle();
    check("t5_rv", 32'(out_valid_o), 0);
    check("t5_ri", 32'(out_idx_o), 0);
    check("t5_rc", 32'(count_o), 0);
    check("t5_rb", 32'(busy_o), 0);
    check("t5_rd", 32'(done_o), 0);
    cyc();
    reset_i = 1'b0;
    cyc();
    settle();
    check("t5_busy",  32'(busy_o), 0);
    check("t5_ready", 32'(load_ready_o), 1);
    check("t5_done",  32'(done_o), 0);
    check("t5_valid", 32'(out_valid_o), 0);

`ifdef SPIKE_SCHED_MERGE_EN
    // Merge {1} into {5,60} while head is 5
    load_valid_i = 1'b1;
    load_vec_i   = '0;
    load_vec_i[5]  = 1'b1;
    load_vec_i[60] = 1'b1;
    out_ready_i  = 1'b0;
    cyc();
    load_valid_i = 1'b0;
    cyc();
    load_valid_i = 1'b1;
    load_vec_i   = 98'h2;
    settle();
    check("t6_h5",    32'(out_idx_o), 5);
    check("t6_ready", 32'(load_ready_o), 1);
    cyc();
    load_valid_i = 1'b0;
    out_ready_i  = 1'b1;
    settle();
    check("t6_i5", 32'(out_idx_o), 5);
    cyc();
    settle();
    check("t6_i1", 32'(out_idx_o), 1);
    check("t6_d1", 32'(done_o), 0);
    cyc();
    settle();
    check("t6_i60", 32'(out_idx_o), 60);
    check("t6_d60", 32'(done_o), 1);
    cyc();
    settle();
    check("t6_cnt", 32'(count_o), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
